// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the dynamic branch predictor: 2-bit counter states,
// reset value and the counter value loaded when an entry is (re)allocated.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t SNT = 2'b00;
    localparam cnt_t WNT = 2'b01;
    localparam cnt_t WT  = 2'b10;
    localparam cnt_t ST  = 2'b11;

    localparam cnt_t CNT_RST = WNT;

    // A freshly allocated entry starts weak in the direction just observed
    function automatic cnt_t cnt_alloc(input logic taken);
        return taken ? WT : WNT;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, resolve-side training and perf-counter signals of the predictor.
// No handshake: lookup is combinational, training is qualified by upd_valid and wen.
interface branch_predictor_if #(
    parameter int PC_W   = 16,
    parameter int PERF_W = 16
);
    logic              wen;
    logic [PC_W-1:0]   PC_curr;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              hit;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_PC;
    logic [PC_W-1:0]   upd_PC_next;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_target;
    logic              mispredict;
    logic [PC_W-1:0]   fix_PC;
    logic [PERF_W-1:0] br_count;
    logic [PERF_W-1:0] mispred_count;

    modport master (
        output wen, PC_curr, upd_valid, upd_PC, upd_PC_next, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, hit, mispredict, fix_PC,
               br_count, mispred_count
    );

    modport slave (
        input  wen, PC_curr, upd_valid, upd_PC, upd_PC_next, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, hit, mispredict, fix_PC,
               br_count, mispred_count
    );

endinterface

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter; purely combinational.
module sat_counter2
    import bp_pkg::*;
(
    input  cnt_t cnt,
    input  logic taken,
    output cnt_t nxt
);

    always_comb begin
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit BHT predictor: zero-cycle lookup from PC_curr, training at the next posedge.
// Stall (wen low) freezes all state; mispredict/fix_PC stay live so consumers can qualify them.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int PC_W    = 16,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 1;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    cnt_t             cnt_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             update;
    cnt_t             cnt_nxt;

    logic             mispredict;
    logic [PERF_W-1:0] br_q;
    logic [PERF_W-1:0] mp_q;

    // Instructions are halfword aligned, so bit 0 never selects anything
    logic unused_pc_lsb;
    assign unused_pc_lsb = bus.PC_curr[0] ^ bus.upd_PC[0];

    assign lk_idx   = bus.PC_curr[IDX_W:1];
    assign lk_tag   = bus.PC_curr[PC_W-1:IDX_W+1];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_q[lk_idx][1];

    assign bus.hit         = lk_hit;
    assign bus.pred_taken  = lk_taken;
    assign bus.pred_target = lk_taken ? target_q[lk_idx] : '0;

    assign up_idx = bus.upd_PC[IDX_W:1];
    assign up_tag = bus.upd_PC[PC_W-1:IDX_W+1];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign update = bus.upd_valid && bus.wen;

    sat_counter2 u_sat_counter2 (
        .cnt   (cnt_q[up_idx]),
        .taken (bus.upd_taken),
        .nxt   (cnt_nxt)
    );

    // Lookup reads the arrays directly, so a same-cycle update to the same
    // index is only visible from the next cycle on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_RST;
            end
        end else if (update) begin
            valid_q[up_idx] <= 1'b1;
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_nxt;
                if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
            end else begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.upd_target;
                cnt_q[up_idx]    <= cnt_alloc(bus.upd_taken);
            end
        end
    end

    assign mispredict = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && bus.upd_pred_taken &&
                          (bus.upd_target != bus.upd_pred_target)));

    assign bus.mispredict = mispredict;
    assign bus.fix_PC     = bus.upd_taken ? bus.upd_target : bus.upd_PC_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (update) begin
            if (br_q != '1) br_q <= br_q + PERF_W'(1);
            if (mispredict && (mp_q != '1)) mp_q <= mp_q + PERF_W'(1);
        end
    end

    assign bus.br_count      = br_q;
    assign bus.mispred_count = mp_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor with branch target buffer, the successor to the static condition-evaluating branch control. It sits beside the fetch stage and predicts taken/not-taken and target for the current PC in the same cycle. It is trained one cycle later from the resolving stage, and flags mispredictions with the corrected PC. It also keeps saturating branch and mispredict performance counters.

## Interface
Parameters:
- `ENTRIES`, default 8: BTB/BHT depth; power of two, ≥ 2. `IDX_W` = log2(`ENTRIES`).
- `PC_W`, default 16: address width.
- `PERF_W`, default 16: performance counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `wen`  in  1  update enable; low during pipeline stall.
- `PC_curr`  in  PC_W  fetch PC to predict.
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  PC_W  predicted target; valid when `pred_taken`.
- `hit`  out  1  valid BTB entry with matching tag.
- `upd_valid`  in  1  a branch is resolving this cycle.
- `upd_PC`  in  PC_W  PC of the resolving branch.
- `upd_PC_next`  in  PC_W  PC+2 of the resolving branch.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  PC_W  actual target.
- `upd_pred_taken`  in  1  prediction made at fetch, piped down.
- `upd_pred_target`  in  PC_W  target predicted at fetch, piped down.
- `mispredict`  out  1  resolving branch was mispredicted.
- `fix_PC`  out  PC_W  correct next PC when `mispredict`.
- `br_count`  out  PERF_W  resolved branches.
- `mispred_count`  out  PERF_W  mispredictions.

## Operation
- **Index and tag.**
  - Index = PC[IDX_W:1]; PC[0] is ignored (halfword-aligned instructions).
  - Tag = PC[PC_W-1:IDX_W+1].
- **Entry contents.** Each entry holds `valid`, `tag`, `target` (PC_W) and a 2-bit saturating counter.
  - Counter encodings: 00 strongly not taken, 01 weakly not taken, 10 weakly taken, 11 strongly taken.
- **Lookup (combinational).**
  - `hit` = valid & tag match.
  - `pred_taken` = `hit` & counter[1].
  - `pred_target` = entry target when `pred_taken`, else 0.
- **Update**, at posedge when `upd_valid & wen`, on the entry at `upd_PC`'s index:
  - Hit:
    - Counter increments on taken, decrements on not taken, saturating at 11 and 00.
    - Target is overwritten with `upd_target` only if `upd_taken`.
  - Miss (invalid or tag mismatch), replace the entry:
    - valid = 1; tag = new tag; target = `upd_target`.
    - Counter = 10 if `upd_taken`, else 01.
- **Mispredict (combinational).**
  - `mispredict` = `upd_valid` & ((`upd_taken` ≠ `upd_pred_taken`) | (`upd_taken` & `upd_pred_taken` & `upd_target` ≠ `upd_pred_target`)).
  - `fix_PC` = `upd_taken` ? `upd_target` : `upd_PC_next`.
  - `mispredict` is not gated by `wen`. Consumers qualify it with their own stall logic.
- **Performance counters.**
  - On `upd_valid & wen`: `br_count` += 1.
  - On `upd_valid & wen & mispredict`: `mispred_count` += 1.
  - Both saturate at all-ones; no wrap.

## Timing
- Lookup latency: 0 cycles (same-cycle, combinational from `PC_curr`).
- Update takes effect at the posedge. The earliest lookup that sees it is in the following cycle.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update state. There is no bypass.
- `wen` low: no table or counter state changes. `mispredict` and `fix_PC` still reflect their inputs.
- Reset, at any time including mid-update:
  - All entries: valid = 0, counter = 01, tag = 0, target = 0.
  - `br_count` = `mispred_count` = 0.
  - Outputs during and after reset: `hit` = 0, `pred_taken` = 0, `pred_target` = 0. `mispredict` and `fix_PC` follow their inputs only.
- Aliasing: two PCs with the same index but different tags evict each other. Training always replaces; there is no replacement policy.

## Structure
- Package `bp_pkg`:
  - Counter encodings `SNT`, `WNT`, `WT`, `ST`.
  - Counter reset value `WNT`.
  - Counter value on allocation (`WT` if taken, `WNT` if not).
- Sub-module `sat_counter2`: next-state function of the 2-bit saturating counter (inputs: current value, outcome). One instance per update port, not per entry.
- Storage is flop arrays, `ENTRIES` deep, asynchronously reset. Perf counters are in the top module.

## Test plan
- Reset, then `PC_curr` = 0x0010 → `hit` = 0, `pred_taken` = 0, `pred_target` = 0, both counters 0.
- Train `upd_PC` = 0x0010, taken, target 0x0040 → next cycle `PC_curr` = 0x0010 gives `hit` = 1, `pred_taken` = 1, `pred_target` = 0x0040.
- Same branch:
  - Train taken three more times → counter = 11.
  - Then two not-taken → counter = 01; lookup gives `pred_taken` = 0, `hit` = 1.
- Alias, with ENTRIES = 8: train 0x0010 taken, then 0x0020 not taken (same index, different tag) → lookup at 0x0010 gives `hit` = 0.
- Mispredict:
  - `upd_pred_taken` = 0, `upd_taken` = 1, `upd_target` = 0x0100 → `mispredict` = 1, `fix_PC` = 0x0100.
  - Not taken, predicted taken, `upd_PC_next` = 0x0032 → `fix_PC` = 0x0032.
  - Both cases increment `mispred_count`.
- Assert `rst` while `upd_valid` and `wen` are high → all entries invalid, counters 0. Perf counters force-loaded at all-ones stay saturated on further updates.
